tsc_control_unit: RTL and testbench

- Multi-cycle control FSM that sequences the TSC CPU datapath: the PC, the IR, the register file, the ALU and the WWD output latch.
- Decodes the 16-bit instruction held in the external IR and drives all write strobes and mux selects.
- Counts retired instructions and implements the cpu_enable stall and HLT stop.
- Sits inside cpu, between the instruction memory/IR and the datapath.

---
 rtl/tsc_control_unit.sv | 164 ++++++++++++++++
 tb/tb_tsc_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tsc_control_unit.sv
// Multi-cycle control FSM for the TSC CPU: decodes the IR, sequences
// IF/ID/EX/WB, drives datapath strobes/selects and counts retired instructions.
module tsc_control_unit #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_cpu,
    input  logic                 cpu_enable,
    input  logic                 wwd_enable,
    input  logic [WORD_SIZE-1:0] instr,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 wb_src,
    output logic                 alu_src_b,
    output logic                 imm_zero_ext,
    output logic [2:0]           alu_op,
    output logic                 output_write,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [WORD_SIZE-1:0] num_inst
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_RALU, C_WWD, C_HLT, C_ADI, C_ORI, C_LHI, C_JMP, C_ILL
    } iclass_t;

    state_t               state_q, state_d;
    iclass_t              iclass;
    logic [WORD_SIZE-1:0] num_inst_q;
    logic [3:0]           opcode;
    logic [5:0]           func;
    logic                 run;
    logic                 ir_w_raw, pc_w_raw, reg_w_raw, out_w_raw;

    assign opcode = instr[15:12];
    assign func   = instr[5:0];
    // Strobes fire only when the FSM is actually allowed to take this edge.
    assign run    = cpu_enable && !reset_cpu;

    always_comb begin
        iclass = C_ILL;
        unique case (opcode)
            4'd15: begin
                if (func <= 6'd7)       iclass = C_RALU;
                else if (func == 6'd28) iclass = C_WWD;
                else if (func == 6'd29) iclass = C_HLT;
                else                    iclass = C_ILL;
            end
            4'd4:    iclass = C_ADI;
            4'd5:    iclass = C_ORI;
            4'd6:    iclass = C_LHI;
            4'd9:    iclass = C_JMP;
            default: iclass = C_ILL;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ir_w_raw     = 1'b0;
        pc_w_raw     = 1'b0;
        reg_w_raw    = 1'b0;
        out_w_raw    = 1'b0;
        pc_src       = 1'b0;
        reg_dst      = 1'b0;
        wb_src       = 1'b0;
        alu_src_b    = 1'b0;
        imm_zero_ext = 1'b0;
        alu_op       = 3'd0;

        // ALU selects are shared by EX and WB so the result stays stable through write-back.
        if (state_q == S_EX || state_q == S_WB) begin
            case (iclass)
                C_RALU: alu_op = func[2:0];
                C_ADI:  alu_src_b = 1'b1;
                C_ORI: begin
                    alu_op       = 3'd3;
                    alu_src_b    = 1'b1;
                    imm_zero_ext = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IF: begin
                ir_w_raw = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                case (iclass)
                    C_JMP: begin
                        pc_w_raw = 1'b1;
                        pc_src   = 1'b1;
                        state_d  = S_IF;
                    end
                    C_ILL: begin
                        pc_w_raw = 1'b1;
                        state_d  = S_IF;
                    end
                    C_LHI:   state_d = S_WB;
                    C_HLT:   state_d = S_HALT;
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (iclass)
                    C_RALU, C_ADI, C_ORI: state_d = S_WB;
                    C_WWD: begin
                        out_w_raw = wwd_enable;
                        pc_w_raw  = 1'b1;
                        state_d   = S_IF;
                    end
                    // IR changed under a stalled instruction: retire it as a NOP.
                    default: begin
                        pc_w_raw = 1'b1;
                        state_d  = S_IF;
                    end
                endcase
            end
            S_WB: begin
                pc_w_raw  = 1'b1;
                reg_w_raw = (iclass == C_RALU || iclass == C_ADI ||
                             iclass == C_ORI  || iclass == C_LHI);
                reg_dst   = (iclass == C_ADI || iclass == C_ORI || iclass == C_LHI);
                wb_src    = (iclass == C_LHI);
                state_d   = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    assign ir_write     = ir_w_raw  && run;
    assign pc_write     = pc_w_raw  && run;
    assign reg_write    = reg_w_raw && run;
    assign output_write = out_w_raw && run;
    assign halted       = (state_q == S_HALT);
    assign state        = state_q;
    assign num_inst     = num_inst_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset_cpu) begin
            state_q    <= S_IF;
            num_inst_q <= '0;
        end else if (cpu_enable) begin
            state_q <= state_d;
            if (pc_write) num_inst_q <= num_inst_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_tsc_control_unit.sv
// Table-driven bench for tsc_control_unit: one row per clock cycle, checking
// the full output vector and the retire count before each rising edge.
module tb_tsc_control_unit;

    logic        clk = 1'b0;
    logic        reset_cpu, cpu_enable, wwd_enable;
    logic [15:0] instr;
    logic        ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src;
    logic        alu_src_b, imm_zero_ext, output_write, halted;
    logic [2:0]  alu_op, state;
    logic [15:0] num_inst;

    int checks   = 0;
    int failures = 0;

    tsc_control_unit #(.WORD_SIZE(16)) dut (
        .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
        .wwd_enable(wwd_enable), .instr(instr),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .wb_src(wb_src),
        .alu_src_b(alu_src_b), .imm_zero_ext(imm_zero_ext), .alu_op(alu_op),
        .output_write(output_write), .halted(halted), .state(state),
        .num_inst(num_inst)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {state[2:0], ir_write, pc_write, pc_src, reg_write,
    // reg_dst, wb_src, alu_src_b, imm_zero_ext, alu_op[2:0], output_write, halted}
    typedef struct {
        logic        rst;
        logic        en;
        logic        wwd;
        logic [15:0] instr;
        logic [15:0] exp_out;
        logic [15:0] exp_num;
    } vec_t;

    vec_t vecs[$];

    localparam logic [15:0] O_RST   = 16'b000_0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [15:0] O_IF    = 16'b000_1_0_0_0_0_0_0_0_000_0_0;
    localparam logic [15:0] O_ID    = 16'b001_0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [15:0] O_IDJ   = 16'b001_0_1_1_0_0_0_0_0_000_0_0;
    localparam logic [15:0] O_IDI   = 16'b001_0_1_0_0_0_0_0_0_000_0_0;
    localparam logic [15:0] O_EXA   = 16'b010_0_0_0_0_0_0_0_0_000_0_0;
    localparam logic [15:0] O_HALT  = 16'b100_0_0_0_0_0_0_0_0_000_0_1;

    task automatic add(input logic rst, input logic en, input logic wwd,
                       input logic [15:0] ins, input logic [15:0] eo,
                       input logic [15:0] en_num);
        vec_t v;
        v.rst = rst; v.en = en; v.wwd = wwd; v.instr = ins;
        v.exp_out = eo; v.exp_num = en_num;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Called right after a falling edge: drive, settle, compare.
    task automatic run_row(input vec_t v, input int idx);
        reset_cpu  = v.rst;
        cpu_enable = v.en;
        wwd_enable = v.wwd;
        instr      = v.instr;
        #1;
        check("outputs", idx,
              {state, ir_write, pc_write, pc_src, reg_write, reg_dst, wb_src,
               alu_src_b, imm_zero_ext, alu_op, output_write, halted}, v.exp_out);
        check("num_inst", idx, num_inst, v.exp_num);
    endtask

    initial begin
        vec_t w;

        // Reset state, then LHI $1,1 (3 cycles)
        add(1, 1, 1, 16'h6101, O_RST, 0);
        add(0, 1, 1, 16'h6101, O_IF, 0);
        add(0, 1, 1, 16'h6101, O_ID, 0);
        add(0, 1, 1, 16'h6101, 16'b011_0_1_0_1_1_1_0_0_000_0_0, 0);
        // ADD $3,$1,$2 (4 cycles)
        add(0, 1, 1, 16'hf6c0, O_IF, 1);
        add(0, 1, 1, 16'hf6c0, O_ID, 1);
        add(0, 1, 1, 16'hf6c0, O_EXA, 1);
        add(0, 1, 1, 16'hf6c0, 16'b011_0_1_0_1_0_0_0_0_000_0_0, 1);
        // ADI: sign-extended immediate, rt destination
        add(0, 1, 1, 16'h47fc, O_IF, 2);
        add(0, 1, 1, 16'h47fc, O_ID, 2);
        add(0, 1, 1, 16'h47fc, 16'b010_0_0_0_0_0_0_1_0_000_0_0, 2);
        add(0, 1, 1, 16'h47fc, 16'b011_0_1_0_1_1_0_1_0_000_0_0, 2);
        // ORI: zero-extended immediate, alu_op ORR
        add(0, 1, 1, 16'h5123, O_IF, 3);
        add(0, 1, 1, 16'h5123, O_ID, 3);
        add(0, 1, 1, 16'h5123, 16'b010_0_0_0_0_0_0_1_1_011_0_0, 3);
        add(0, 1, 1, 16'h5123, 16'b011_0_1_0_1_1_0_1_1_011_0_0, 3);
        // WWD with and without wwd_enable
        add(0, 1, 1, 16'hf81c, O_IF, 4);
        add(0, 1, 1, 16'hf81c, O_ID, 4);
        add(0, 1, 1, 16'hf81c, 16'b010_0_1_0_0_0_0_0_0_000_1_0, 4);
        add(0, 1, 0, 16'hf81c, O_IF, 5);
        add(0, 1, 0, 16'hf81c, O_ID, 5);
        add(0, 1, 0, 16'hf81c, 16'b010_0_1_0_0_0_0_0_0_000_0_0, 5);
        // JMP 21
        add(0, 1, 1, 16'h9015, O_IF, 6);
        add(0, 1, 1, 16'h9015, O_IDJ, 6);
        // SHR (func 7)
        add(0, 1, 1, 16'hf6c7, O_IF, 7);
        add(0, 1, 1, 16'hf6c7, O_ID, 7);
        add(0, 1, 1, 16'hf6c7, 16'b010_0_0_0_0_0_0_0_0_111_0_0, 7);
        add(0, 1, 1, 16'hf6c7, 16'b011_0_1_0_1_0_0_0_0_111_0_0, 7);
        // Illegal opcode, and opcode 15 with an unused func
        add(0, 1, 1, 16'h1234, O_IF, 8);
        add(0, 1, 1, 16'h1234, O_IDI, 8);
        add(0, 1, 1, 16'hf008, O_IF, 9);
        add(0, 1, 1, 16'hf008, O_IDI, 9);
        // ADD with stalls in IF, EX (3 cycles) and WB
        add(0, 0, 1, 16'hf6c0, O_RST, 10);
        add(0, 1, 1, 16'hf6c0, O_IF, 10);
        add(0, 1, 1, 16'hf6c0, O_ID, 10);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 16'hf6c0, O_EXA, 10);
        add(0, 1, 1, 16'hf6c0, O_EXA, 10);
        add(0, 0, 1, 16'hf6c0, 16'b011_0_0_0_0_0_0_0_0_000_0_0, 10);
        add(0, 1, 1, 16'hf6c0, 16'b011_0_1_0_1_0_0_0_0_000_0_0, 10);
        // HLT, 10 cycles parked, then reset out of S_HALT
        add(0, 1, 1, 16'hf01d, O_IF, 11);
        add(0, 1, 1, 16'hf01d, O_ID, 11);
        for (int i = 0; i < 10; i++) add(0, 1, 1, 16'hf01d, O_HALT, 11);
        add(1, 1, 1, 16'hf01d, O_HALT, 11);
        add(0, 1, 1, 16'h9015, O_IF, 0);
        add(0, 1, 1, 16'h9015, O_IDJ, 0);
        // Reset asserted in WB of LHI: no strobes, back to IF with count cleared
        add(0, 1, 1, 16'h6101, O_IF, 1);
        add(0, 1, 1, 16'h6101, O_ID, 1);
        add(1, 1, 1, 16'h6101, 16'b011_0_0_0_0_1_1_0_0_000_0_0, 1);
        add(0, 1, 1, 16'h9015, O_IF, 0);
        add(0, 1, 1, 16'h9015, O_IDJ, 0);

        reset_cpu  = 1'b1;
        cpu_enable = 1'b1;
        wwd_enable = 1'b1;
        instr      = 16'h6101;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            run_row(vecs[i], i);
        end

        // Counter wrap: seed the count at 16'hFFFF, then retire one JMP.
        @(negedge clk);
        dut.num_inst_q = 16'hFFFF;
        w = '{rst: 1'b0, en: 1'b1, wwd: 1'b1, instr: 16'h9015,
              exp_out: O_IF, exp_num: 16'hFFFF};
        run_row(w, 1000);
        @(negedge clk);
        w.exp_out = O_IDJ;
        run_row(w, 1001);
        @(negedge clk);
        w.exp_out = O_IF;
        w.exp_num = 16'h0000;
        run_row(w, 1002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
